// File: rtl/seq_ctrl_pkg.sv
// seq_ctrl_pkg: shared opcodes, ALU selects, FSM states and instruction field positions.
package seq_ctrl_pkg;
  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_ADDI = 4'h5,
    OP_BEQ  = 4'h6,
    OP_HALT = 4'hF
  } opcode_e;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_e;
  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;
  localparam int OP_LO  = 16;
  localparam int RD_LO  = 12;
  localparam int RS1_LO = 8;
  localparam int RS2_LO = 4;
  localparam int IMM_LO = 0;
endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: combinational decode of the held instruction into datapath controls.
module instr_decoder
  import seq_ctrl_pkg::*;
(
  input  logic [19:0] i_ir,
  output logic [3:0]  o_ra1,
  output logic [3:0]  o_ra2,
  output logic [3:0]  o_wa,
  output logic        o_we_raw,
  output logic        o_alu_src,
  output logic [1:0]  o_alu_ctrl,
  output logic [7:0]  o_imm,
  output logic        o_is_branch,
  output logic        o_is_halt
);
  logic [3:0] w_op;
  assign w_op        = i_ir[OP_LO+:4];
  assign o_ra1       = i_ir[RS1_LO+:4];
  assign o_ra2       = i_ir[RS2_LO+:4];
  assign o_wa        = i_ir[RD_LO+:4];
  assign o_imm       = i_ir[IMM_LO+:8];
  // r0 is hardwired, so writes to it are suppressed here
  assign o_we_raw    = w_op >= OP_ADD && w_op <= OP_ADDI && o_wa != 4'd0;
  assign o_alu_src   = w_op == OP_ADDI;
  assign o_alu_ctrl  = (w_op == OP_SUB || w_op == OP_BEQ) ? ALU_SUB :
                       w_op == OP_AND ? ALU_AND :
                       w_op == OP_OR  ? ALU_OR  : ALU_ADD;
  assign o_is_branch = w_op == OP_BEQ;
  assign o_is_halt   = w_op == OP_HALT;
endmodule

// File: rtl/instr_seq_ctrl.sv
// instr_seq_ctrl: fetch/execute sequencer driving register-file/ALU controls.
// Controls are decoded from IR, which only changes on fetch, so they hold between EXECs.
module instr_seq_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int IW   = 20
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [IW-1:0]   imem_data,
  input  logic            Zero,
  output logic [3:0]      RA1,
  output logic [3:0]      RA2,
  output logic [3:0]      WA,
  output logic            write_enable,
  output logic            ALUSrc,
  output logic [1:0]      ALUControl,
  output logic [7:0]      immediate,
  output logic            busy,
  output logic            halted,
  output logic [15:0]     retired
);
  state_e          r_state, w_next;
  logic [PC_W-1:0] r_pc;
  logic [IW-1:0]   r_ir;
  logic [15:0]     r_retired;
  logic            w_we_raw, w_is_branch, w_is_halt;
  instr_decoder u_dec (
    .i_ir        (r_ir),
    .o_ra1       (RA1),
    .o_ra2       (RA2),
    .o_wa        (WA),
    .o_we_raw    (w_we_raw),
    .o_alu_src   (ALUSrc),
    .o_alu_ctrl  (ALUControl),
    .o_imm       (immediate),
    .o_is_branch (w_is_branch),
    .o_is_halt   (w_is_halt)
  );
  always_comb begin
    w_next = r_state;
    w_next = r_state == S_IDLE  ? (start ? S_FETCH : S_IDLE) :
             r_state == S_FETCH ? (imem_valid ? S_EXEC : S_FETCH) :
             r_state == S_EXEC  ? (w_is_halt ? S_HALT : S_FETCH) : S_HALT;
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_ir      <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH && imem_valid) r_ir <= imem_data;
      if (r_state == S_EXEC) begin
        r_pc      <= (w_is_branch && Zero) ? PC_W'(immediate) : r_pc + PC_W'(1);
        r_retired <= r_retired + 16'd1;
      end
    end
  end
  assign imem_req     = r_state == S_FETCH;
  assign imem_addr    = r_pc;
  assign write_enable = w_we_raw && r_state == S_EXEC;
  assign busy         = r_state == S_FETCH || r_state == S_EXEC;
  assign halted       = r_state == S_HALT;
  assign retired      = r_retired;
endmodule

// File: tb/tb_instr_seq_ctrl.sv
// tb_instr_seq_ctrl: randomized fetch/execute checks against a spec-level model of PC, retire count and decode.
module tb_instr_seq_ctrl;
  logic        clk = 0, nrst = 0, start = 0, imem_valid = 0, zero = 0;
  logic [19:0] imem_data = 0;
  logic        imem_req, write_enable, alu_src, busy, halted;
  logic [7:0]  imem_addr, immediate;
  logic [3:0]  ra1, ra2, wa;
  logic [1:0]  alu_ctl;
  logic [15:0] retired;
  int          n_cmp = 0, n_err = 0;
  logic [7:0]  mpc = 0;
  logic [15:0] mret = 0;

  typedef struct {
    logic [7:0] addr;
    bit         stable;
    int         req_cycles;
    logic [3:0] ra1, ra2, wa;
    logic       we, src, busy_x;
    logic [1:0] ctl;
    logic [7:0] imm;
    logic       req_after;
  } obs_t;

  instr_seq_ctrl dut (
    .CLK(clk), .nRST(nrst), .start(start), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_data(imem_data), .Zero(zero), .RA1(ra1), .RA2(ra2),
    .WA(wa), .write_enable(write_enable), .ALUSrc(alu_src), .ALUControl(alu_ctl),
    .immediate(immediate), .busy(busy), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] exp_ctl(input logic [19:0] ins);
    case (ins[19:16])
      4'h2, 4'h6: return 2'b11;
      4'h3:       return 2'b00;
      4'h4:       return 2'b01;
      default:    return 2'b10;
    endcase
  endfunction

  function automatic logic exp_we(input logic [19:0] ins);
    return ins[19:16] >= 4'h1 && ins[19:16] <= 4'h5 && ins[15:12] != 4'h0;
  endfunction

  // Architectural effect of completing one instruction
  task automatic model_step(input logic [19:0] ins, input logic z);
    mpc  = (ins[19:16] == 4'h6 && z) ? ins[7:0] : mpc + 8'd1;
    mret = mret + 16'd1;
  endtask

  // Starts in FETCH at posedge+1; acts as instruction memory; ends at posedge+1 after EXEC.
  task automatic do_instr(input logic [19:0] ins, input int waits, input logic z, output obs_t o);
    o.addr = imem_addr; o.stable = 1; o.req_cycles = 0;
    for (int w = 0; w <= waits; w++) begin
      imem_valid = (w == waits);
      imem_data  = (w == waits) ? ins : 20'($urandom);
      @(negedge clk);
      if (imem_req) o.req_cycles++;
      if (!imem_req || imem_addr !== o.addr) o.stable = 0;
      @(posedge clk); #1;
    end
    imem_valid = 1; imem_data = 20'($urandom); zero = z;
    @(negedge clk);
    o.ra1 = ra1; o.ra2 = ra2; o.wa = wa; o.we = write_enable; o.src = alu_src;
    o.ctl = alu_ctl; o.imm = immediate; o.busy_x = busy;
    @(posedge clk); #1;
    imem_valid = 0; zero = 0;
    o.req_after = imem_req;
    model_step(ins, z);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic test_reset();
    nrst = 0; #12;
    n_cmp++; if (imem_req !== 0) begin n_err++; $display("FAIL rst_req got %0b want 0", imem_req); end
    n_cmp++; if (imem_addr !== 0) begin n_err++; $display("FAIL rst_addr got %0h want 0", imem_addr); end
    n_cmp++; if ({ra1, ra2, wa} !== 12'h0) begin n_err++; $display("FAIL rst_addrs got %0h want 0", {ra1, ra2, wa}); end
    n_cmp++; if ({write_enable, alu_src, alu_ctl} !== 4'b0010) begin n_err++; $display("FAIL rst_ctl got %0b want 0010", {write_enable, alu_src, alu_ctl}); end
    n_cmp++; if ({immediate, busy, halted, retired} !== 26'h0) begin n_err++; $display("FAIL rst_misc got %0h want 0", {immediate, busy, halted, retired}); end
    #3 nrst = 1; mpc = 0; mret = 0;
    imem_valid = 1; imem_data = 20'h51005;
    repeat (3) @(posedge clk);
    @(negedge clk);
    imem_valid = 0;
    n_cmp++; if (imem_req !== 0 || busy !== 0) begin n_err++; $display("FAIL idle_req got %0b/%0b want 0/0", imem_req, busy); end
    n_cmp++; if (retired !== 0) begin n_err++; $display("FAIL idle_ret got %0d want 0", retired); end
  endtask

  task automatic test_addi();
    obs_t o;
    pulse_start();
    n_cmp++; if (imem_req !== 1 || busy !== 1) begin n_err++; $display("FAIL start_req got %0b/%0b want 1/1", imem_req, busy); end
    do_instr(20'h51005, 0, 0, o);
    n_cmp++; if (o.wa !== 4'd1 || o.ra1 !== 4'd0) begin n_err++; $display("FAIL addi_regs got wa=%0h ra1=%0h want 1/0", o.wa, o.ra1); end
    n_cmp++; if (o.src !== 1 || o.imm !== 8'h05 || o.ctl !== 2'b10) begin n_err++; $display("FAIL addi_ctl got src=%0b imm=%0h ctl=%0b want 1/05/10", o.src, o.imm, o.ctl); end
    n_cmp++; if (o.we !== 1) begin n_err++; $display("FAIL addi_we got %0b want 1", o.we); end
    n_cmp++; if (retired !== mret || mret !== 16'd1) begin n_err++; $display("FAIL addi_ret got %0d want 1", retired); end
    n_cmp++; if (imem_addr !== mpc) begin n_err++; $display("FAIL addi_pc got %0h want %0h", imem_addr, mpc); end
  endtask

  task automatic test_wait();
    obs_t o;
    logic [15:0] r0;
    r0 = retired;
    do_instr(20'h12340, 3, 0, o);
    n_cmp++; if (o.req_cycles !== 4 || !o.stable) begin n_err++; $display("FAIL wait_req got cycles=%0d stable=%0b want 4/1", o.req_cycles, o.stable); end
    n_cmp++; if (retired !== r0 + 16'd1) begin n_err++; $display("FAIL wait_ret got %0d want %0d", retired, r0 + 16'd1); end
    n_cmp++; if (o.req_after !== 1 || write_enable !== 0) begin n_err++; $display("FAIL wait_next got req=%0b we=%0b want 1/0", o.req_after, write_enable); end
  endtask

  task automatic test_beq();
    obs_t o;
    do_instr(20'h60110, 0, 1, o);
    n_cmp++; if (o.ctl !== 2'b11 || o.we !== 0) begin n_err++; $display("FAIL beq_ctl got ctl=%0b we=%0b want 11/0", o.ctl, o.we); end
    n_cmp++; if (imem_addr !== 8'h10) begin n_err++; $display("FAIL beq_taken got %0h want 10", imem_addr); end
    do_instr(20'h60110, 1, 0, o);
    n_cmp++; if (imem_addr !== 8'h11) begin n_err++; $display("FAIL beq_not_taken got %0h want 11", imem_addr); end
  endtask

  task automatic test_add_r0();
    obs_t o;
    do_instr(20'h10120, 0, 0, o);
    n_cmp++; if (o.we !== 0 || o.wa !== 4'd0 || o.src !== 0) begin n_err++; $display("FAIL add_r0 got we=%0b wa=%0h src=%0b want 0/0/0", o.we, o.wa, o.src); end
  endtask

  task automatic test_random();
    obs_t o;
    logic [19:0] ins;
    logic        z;
    int          w;
    for (int i = 0; i < 40; i++) begin
      ins = 20'($urandom);
      ins[19:16] = 4'($urandom_range(0, 14));
      z = 1'($urandom);
      w = $urandom_range(0, 3);
      n_cmp++; if (imem_addr !== mpc) begin n_err++; $display("FAIL rnd%0d_addr got %0h want %0h", i, imem_addr, mpc); end
      do_instr(ins, w, z, o);
      n_cmp++; if ({o.ra1, o.ra2, o.wa} !== {ins[11:8], ins[7:4], ins[15:12]}) begin n_err++; $display("FAIL rnd%0d_regs ins=%05h got %03h want %03h", i, ins, {o.ra1, o.ra2, o.wa}, {ins[11:8], ins[7:4], ins[15:12]}); end
      n_cmp++; if (o.we !== exp_we(ins)) begin n_err++; $display("FAIL rnd%0d_we ins=%05h got %0b want %0b", i, ins, o.we, exp_we(ins)); end
      n_cmp++; if (o.ctl !== exp_ctl(ins) || o.src !== (ins[19:16] == 4'h5)) begin n_err++; $display("FAIL rnd%0d_alu ins=%05h got ctl=%0b src=%0b", i, ins, o.ctl, o.src); end
      n_cmp++; if (o.imm !== ins[7:0]) begin n_err++; $display("FAIL rnd%0d_imm got %0h want %0h", i, o.imm, ins[7:0]); end
      n_cmp++; if (o.req_cycles !== w + 1 || !o.stable || !o.busy_x) begin n_err++; $display("FAIL rnd%0d_fetch got cycles=%0d stable=%0b want %0d/1", i, o.req_cycles, o.stable, w + 1); end
      n_cmp++; if (retired !== mret) begin n_err++; $display("FAIL rnd%0d_ret got %0d want %0d", i, retired, mret); end
    end
    n_cmp++; if (imem_addr !== mpc) begin n_err++; $display("FAIL rnd_final_addr got %0h want %0h", imem_addr, mpc); end
  endtask

  task automatic test_wrap();
    obs_t o;
    do_instr(20'h600FF, 0, 1, o);
    n_cmp++; if (imem_addr !== 8'hFF) begin n_err++; $display("FAIL wrap_jump got %0h want ff", imem_addr); end
    do_instr(20'h0ABCD, 0, 1, o);
    n_cmp++; if (o.we !== 0 || imem_addr !== 8'h00) begin n_err++; $display("FAIL wrap_next got we=%0b addr=%0h want 0/00", o.we, imem_addr); end
  endtask

  task automatic test_halt();
    obs_t o;
    do_instr(20'hF1234, 0, 0, o);
    n_cmp++; if (o.we !== 0) begin n_err++; $display("FAIL halt_we got %0b want 0", o.we); end
    n_cmp++; if (halted !== 1 || busy !== 0 || imem_req !== 0) begin n_err++; $display("FAIL halt_state got h=%0b b=%0b r=%0b want 1/0/0", halted, busy, imem_req); end
    n_cmp++; if (retired !== mret) begin n_err++; $display("FAIL halt_ret got %0d want %0d", retired, mret); end
    pulse_start();
    imem_valid = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    imem_valid = 0;
    n_cmp++; if (halted !== 1 || imem_req !== 0 || retired !== mret) begin n_err++; $display("FAIL halt_hold got h=%0b r=%0b ret=%0d want 1/0/%0d", halted, imem_req, retired, mret); end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    @(posedge clk); #1 nrst = 0; #3 nrst = 1; mpc = 0; mret = 0;
    pulse_start();
    do_instr(20'h52001, 0, 0, o);
    imem_valid = 0;
    @(negedge clk);
    n_cmp++; if (imem_addr !== 8'h01 || retired !== 16'd1) begin n_err++; $display("FAIL midf_pre got addr=%0h ret=%0d want 01/1", imem_addr, retired); end
    #1 nrst = 0; #1;
    n_cmp++; if (imem_req !== 0 || busy !== 0 || imem_addr !== 0 || retired !== 0) begin n_err++; $display("FAIL midf_rst got req=%0b busy=%0b addr=%0h ret=%0d want 0", imem_req, busy, imem_addr, retired); end
    #1 nrst = 1;
    pulse_start();
    imem_valid = 1; imem_data = 20'h53207;
    @(posedge clk); #1 imem_valid = 0;
    @(negedge clk);
    n_cmp++; if (write_enable !== 1 || wa !== 4'd3) begin n_err++; $display("FAIL mide_pre got we=%0b wa=%0h want 1/3", write_enable, wa); end
    #1 nrst = 0; #1;
    n_cmp++; if (write_enable !== 0 || wa !== 0 || immediate !== 0 || alu_ctl !== 2'b10 || alu_src !== 0) begin n_err++; $display("FAIL mide_rst got we=%0b wa=%0h imm=%0h ctl=%0b src=%0b", write_enable, wa, immediate, alu_ctl, alu_src); end
    #1 nrst = 1;
    @(posedge clk); @(negedge clk);
    n_cmp++; if (retired !== 0 || busy !== 0) begin n_err++; $display("FAIL mide_after got ret=%0d busy=%0b want 0/0", retired, busy); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_wait();
    test_beq();
    test_add_r0();
    test_random();
    test_wrap();
    test_halt();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
